// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: aligns address, builds byte enables, extends load data.
// Latency: 3 cycles (IDLE, BUSY, DONE) with zero-wait ack; BUSY stretches with memory wait states.
// Backpressure: pipe_stall holds the pipeline while a request is pending; mem_req is held until mem_ack.
module mem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        ex_type,
    input  logic              unsigned_ld,
    output logic              pipe_stall,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid,
    output logic              err_o,
    output logic [1:0]        err_code,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [7:0] LAST_WAIT    = 8'(MAX_WAIT - 1);

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic [1:0]          r_off;
    logic [1:0]          r_type;
    logic                r_uns;
    logic                r_we;
    logic                r_mem_req;
    logic [3:0]          r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [31:0]         r_rdata;
    logic                r_rdata_vld;
    logic                r_err;
    logic [1:0]          r_err_code;

    logic                w_req;
    logic                w_misaligned;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata_rep;
    logic [7:0]          w_lane8;
    logic [15:0]         w_lane16;
    logic [31:0]         w_ld_ext;

    assign w_req = is_load | is_store;

    // Alignment check on the incoming access; type 11 behaves like a word
    always_comb begin
        w_misaligned = 1'b0;
        case (ex_type)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = addr[0];
            default: w_misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming access
    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = wdata;
        case (ex_type)
            2'b00: begin
                w_be        = 4'b0001 << addr[1:0];
                w_wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be        = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word using the captured offset
    always_comb begin
        w_lane8 = mem_rdata[7:0];
        case (r_off)
            2'b00: w_lane8 = mem_rdata[7:0];
            2'b01: w_lane8 = mem_rdata[15:8];
            2'b10: w_lane8 = mem_rdata[23:16];
            2'b11: w_lane8 = mem_rdata[31:24];
        endcase
        w_lane16 = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Sign- or zero-extend the selected lane to a full word
    always_comb begin
        w_ld_ext = mem_rdata;
        case (r_type)
            2'b00:   w_ld_ext = {{24{~r_uns & w_lane8[7]}}, w_lane8};
            2'b01:   w_ld_ext = {{16{~r_uns & w_lane16[15]}}, w_lane16};
            default: w_ld_ext = mem_rdata;
        endcase
    end

    // Stall while a new request is being accepted or the memory is outstanding;
    // gated by reset so a held instruction cannot stall a design in reset.
    assign pipe_stall = rst_n & (((r_state == S_IDLE) & w_req) | (r_state == S_BUSY));

    // Access sequencer: captures the request, waits for ack or timeout, reports result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_off       <= 2'b00;
            r_type      <= 2'b00;
            r_uns       <= 1'b0;
            r_we        <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_rdata_vld <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_rdata_vld <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_misaligned) begin
                            r_err_code <= ERR_MISALIGN;
                            r_err      <= 1'b1;
                            r_state    <= S_ERR;
                        end else begin
                            r_off       <= addr[1:0];
                            r_type      <= ex_type;
                            r_uns       <= unsigned_ld;
                            r_we        <= is_store;
                            r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata_rep;
                            r_mem_req   <= 1'b1;
                            r_cnt       <= 8'd0;
                            r_state     <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_we) begin
                            r_rdata     <= w_ld_ext;
                            r_rdata_vld <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == LAST_WAIT) begin
                        r_mem_req  <= 1'b0;
                        r_err_code <= ERR_TIMEOUT;
                        r_err      <= 1'b1;
                        r_state    <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_we;
    assign mem_be      = r_mem_be;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign rdata_o     = r_rdata;
    assign rdata_valid = r_rdata_vld;
    assign err_o       = r_err;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stores, loads, misalignment, timeout, mid-access reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled before the next edge.
// Memory ack is driven directly from the stimulus with a known number of wait cycles.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        is_load;
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  ex_type;
    logic        unsigned_ld;
    logic        pipe_stall;
    logic [31:0] rdata_o;
    logic        rdata_valid;
    logic        err_o;
    logic [1:0]  err_code;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests;
    int fails;

    // Values captured during the last access
    int          stall_cnt;
    int          req_cnt;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .is_load     (is_load),
        .is_store    (is_store),
        .addr        (addr),
        .wdata       (wdata),
        .ex_type     (ex_type),
        .unsigned_ld (unsigned_ld),
        .pipe_stall  (pipe_stall),
        .rdata_o     (rdata_o),
        .rdata_valid (rdata_valid),
        .err_o       (err_o),
        .err_code    (err_code),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one aligned access; returns in the DONE cycle with inputs cleared
    task automatic access(input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] t, input logic u,
                          input int waits, input logic [31:0] rd);
        is_load = ld; is_store = st; addr = a; wdata = wd; ex_type = t; unsigned_ld = u;
        #1;
        stall_cnt = 0;
        req_cnt   = 0;
        if (pipe_stall) stall_cnt++;
        if (mem_req) req_cnt++;
        cyc();
        cap_be = mem_be; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
        for (int i = 0; i < waits; i++) begin
            if (pipe_stall) stall_cnt++;
            if (mem_req) req_cnt++;
            cyc();
        end
        mem_ack = 1'b1; mem_rdata = rd;
        #1;
        if (pipe_stall) stall_cnt++;
        if (mem_req) req_cnt++;
        cyc();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        is_load = 1'b0; is_store = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        tests = 0; fails = 0;
        rst_n = 1'b0; is_load = 1'b0; is_store = 1'b0; addr = 32'd0; wdata = 32'd0;
        ex_type = 2'b00; unsigned_ld = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) cyc();

        // Reset state
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_errcode", 32'(err_code), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Store byte at 0x1003, zero-wait ack
        access(1'b0, 1'b1, 32'h1003, 32'h0000_00A5, 2'b00, 1'b0, 0, 32'd0);
        chk("sb_addr", cap_addr, 32'h1000);
        chk("sb_be", 32'(cap_be), 32'h8);
        chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("sb_we", 32'(cap_we), 32'd1);
        chk("sb_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("sb_done_stall", 32'(pipe_stall), 32'd0);
        chk("sb_no_rvalid", 32'(rdata_valid), 32'd0);
        chk("sb_req_dropped", 32'(mem_req), 32'd0);
        cyc();
        chk("sb_idle_rvalid", 32'(rdata_valid), 32'd0);

        // Signed half load at 0x2002 with 3 wait cycles
        access(1'b1, 1'b0, 32'h2002, 32'd0, 2'b01, 1'b0, 3, 32'h80F0_1234);
        chk("lhs_be", 32'(cap_be), 32'hC);
        chk("lhs_addr", cap_addr, 32'h2000);
        chk("lhs_we", 32'(cap_we), 32'd0);
        chk("lhs_req_cycles", 32'(req_cnt), 32'd4);
        chk("lhs_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("lhs_rvalid", 32'(rdata_valid), 32'd1);
        chk("lhs_rdata", rdata_o, 32'hFFFF_80F0);
        cyc();
        chk("lhs_rvalid_pulse", 32'(rdata_valid), 32'd0);
        chk("lhs_rdata_hold", rdata_o, 32'hFFFF_80F0);

        // Same load, zero-extended
        access(1'b1, 1'b0, 32'h2002, 32'd0, 2'b01, 1'b1, 0, 32'h80F0_1234);
        chk("lhu_rdata", rdata_o, 32'h0000_80F0);
        chk("lhu_rvalid", 32'(rdata_valid), 32'd1);
        cyc();

        // A store must leave the load result untouched
        access(1'b0, 1'b1, 32'h0010, 32'h1234_5678, 2'b10, 1'b0, 1, 32'hFFFF_FFFF);
        chk("sw_be", 32'(cap_be), 32'hF);
        chk("sw_wdata", cap_wdata, 32'h1234_5678);
        chk("sw_rdata_kept", rdata_o, 32'h0000_80F0);
        cyc();

        // Byte unsigned load and word load
        access(1'b1, 1'b0, 32'h0001, 32'd0, 2'b00, 1'b1, 0, 32'h1122_3344);
        chk("lbu_be", 32'(cap_be), 32'h2);
        chk("lbu_rdata", rdata_o, 32'h0000_0033);
        cyc();
        access(1'b1, 1'b0, 32'h0004, 32'd0, 2'b10, 1'b0, 0, 32'h1122_3344);
        chk("lw_addr", cap_addr, 32'h0004);
        chk("lw_rdata", rdata_o, 32'h1122_3344);
        cyc();

        // Misaligned word load
        is_load = 1'b1; addr = 32'h0006; ex_type = 2'b10; unsigned_ld = 1'b0;
        #1;
        chk("mis_stall_idle", 32'(pipe_stall), 32'd1);
        cyc();
        is_load = 1'b0;
        #1;
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_err", 32'(err_o), 32'd1);
        chk("mis_code", 32'(err_code), 32'h1);
        chk("mis_stall_err", 32'(pipe_stall), 32'd0);
        cyc();
        chk("mis_err_pulse", 32'(err_o), 32'd0);
        chk("mis_code_hold", 32'(err_code), 32'h1);
        chk("mis_req_idle", 32'(mem_req), 32'd0);

        // Word store with no ack: timeout
        is_store = 1'b1; addr = 32'h0040; wdata = 32'hDEAD_BEEF; ex_type = 2'b10;
        cyc();
        is_store = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            cyc();
        end
        chk("to_req_cycles", 32'(n), 32'd15);
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_code", 32'(err_code), 32'h2);
        chk("to_stall", 32'(pipe_stall), 32'd0);
        cyc();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        cyc();
        chk("stray_req", 32'(mem_req), 32'd0);
        chk("stray_rvalid", 32'(rdata_valid), 32'd0);
        chk("stray_stall", 32'(pipe_stall), 32'd0);
        cyc();
        chk("stray_rdata", rdata_o, 32'h1122_3344);
        mem_ack = 1'b0; mem_rdata = 32'd0;
        cyc();

        // Reset asserted while BUSY
        is_load = 1'b1; addr = 32'h0080; ex_type = 2'b10; unsigned_ld = 1'b0;
        cyc();
        chk("rb_req_busy", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rb_req", 32'(mem_req), 32'd0);
        chk("rb_stall", 32'(pipe_stall), 32'd0);
        chk("rb_rdata", rdata_o, 32'd0);
        chk("rb_code", 32'(err_code), 32'd0);
        chk("rb_addr", mem_addr, 32'd0);
        is_load = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        access(1'b1, 1'b0, 32'h0004, 32'd0, 2'b10, 1'b0, 2, 32'h5566_7788);
        chk("rb_after_rvalid", 32'(rdata_valid), 32'd1);
        chk("rb_after_rdata", rdata_o, 32'h5566_7788);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register. It converts the registered address, store data, access type and signedness into a word-aligned request with byte enables on a variable-latency ack-based memory port. It stalls the pipeline while the access is outstanding and returns the extended load data to the writeback path. It also flags misaligned accesses and memory timeouts.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width (fixed 32; 4 byte lanes)
MAX_WAIT, 15, maximum BUSY cycles without mem_ack before timeout (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
is_load  in  1  MEM-stage instruction is a load
is_store  in  1  MEM-stage instruction is a store (wins if both set)
addr  in  ADDR_W  byte address (ALU result)
wdata  in  32  store data (rs2)
ex_type  in  2  00 byte, 01 half, 10 word, 11 treated as word
unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend
pipe_stall  out  1  hold all pipeline registers this cycle
rdata_o  out  32  extended load result
rdata_valid  out  1  one-cycle pulse, load complete
err_o  out  1  one-cycle pulse, access aborted
err_code  out  2  01 misaligned, 10 timeout; valid with err_o
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory accepted/completed request
mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset: state IDLE; every output 0, including pipe_stall, mem_req, rdata_o, err_code and counter. Reset is asynchronous. Asserting it mid-access drops mem_req immediately and abandons the access.
- req = is_load | is_store.
- Misalignment rules:
  - half with addr[0]=1 is misaligned;
  - word or type 11 with addr[1:0]!=0 is misaligned;
  - byte is never misaligned.
- FSM states IDLE, BUSY, DONE, ERR.
  - IDLE, req and aligned: capture addr[1:0], ex_type, unsigned_ld, we=is_store; register mem_addr={addr[ADDR_W-1:2],2'b00}, mem_be, mem_wdata; mem_req<=1; go BUSY.
  - IDLE, req and misaligned: no memory access; err_code<=01; go ERR.
  - BUSY, mem_ack=1: mem_req<=0; if load, rdata_o<=extended data; go DONE.
  - BUSY, no ack, counter==MAX_WAIT-1: mem_req<=0; err_code<=10; go ERR. Otherwise the counter increments.
  - DONE: rdata_valid=1 if load; go IDLE unconditionally.
  - ERR: err_o=1; go IDLE unconditionally.
- pipe_stall is combinational: 1 when (IDLE and req) or BUSY; 0 in DONE and ERR. The pipeline advances on the DONE/ERR cycle edge, so the next instruction is first seen in IDLE.
- Latency: with zero-wait ack, a request takes 3 cycles (IDLE, BUSY, DONE) and the stall lasts 2 cycles.
- mem_req, mem_addr, mem_we, mem_be and mem_wdata are stable from BUSY entry until the ack cycle. mem_ack is ignored outside BUSY. The counter is cleared on BUSY entry.
- Byte enables and store data:
  - byte: be=1<<addr[1:0], wdata={4{wdata[7:0]}};
  - half: be = addr[1] ? 1100 : 0011, wdata={2{wdata[15:0]}};
  - word: be=1111, wdata unchanged.
- Load extension: select the lane from the captured addr[1:0]/ex_type, then sign- or zero-extend to 32. rdata_o holds its value until the next load completion. Stores never update rdata_o.
- err_code holds its value until the next error.

Test Plan:
- Store byte, addr=0x1003, wdata=0x000000A5, ack on the first BUSY cycle -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1; pipe_stall high for 2 cycles; no rdata_valid.
- Load half signed, addr=0x2002, mem_rdata=0x80F01234, ack after 3 wait cycles -> mem_be=1100, rdata_o=0xFFFF80F0, rdata_valid pulses once; repeat with unsigned_ld=1 -> 0x000080F0.
- Load byte unsigned, addr=0x0001, mem_rdata=0x11223344 -> rdata_o=0x00000033; word load at 0x0004 -> 0x11223344.
- Misaligned word load at addr=0x0006 -> mem_req never asserts; err_o pulse with err_code=01 on the second cycle; pipe_stall high for 1 cycle.
- Word store with no ack, MAX_WAIT=15 -> mem_req high for exactly 15 cycles then drops; err_o with err_code=10; FSM returns to IDLE; a stray mem_ack afterwards is ignored.
- rst_n pulled low during BUSY -> mem_req, pipe_stall and all outputs go to 0 immediately; after release, a new load completes normally.
